// File: rtl/data_mem_mmio.sv
// Data-memory responder for a single-cycle core: word RAM plus a small MMIO
// window with a 64-bit cycle counter, a compare timer and a byte TX FIFO.
module data_mem_mmio #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o,
    output logic        bus_err_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] OFF_CYCLE_LO = 3'd0;
    localparam logic [2:0] OFF_CYCLE_HI = 3'd1;
    localparam logic [2:0] OFF_TIMECMP  = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_TXDATA   = 3'd4;

    // The FIFO count field in STATUS is only four bits wide.
    function automatic logic [3:0] sat_count(input logic [PW:0] c);
        logic [31:0] c32;
        c32 = 32'(c);
        if (c32 > 32'd15) return 4'hf;
        return c32[3:0];
    endfunction

    logic [31:0]   mem [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [63:0]   cyc_cnt;
    logic [31:0]   hi_shadow;
    logic [31:0]   timecmp;
    logic          irq;
    logic          overflow;
    logic          bus_err;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_cnt;

    logic          ram_hit;
    logic          mmio_hit;
    logic [2:0]    offset;
    logic [AW-1:0] ram_idx;
    logic          ld;
    logic          st;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          do_push;
    logic          irq_set;
    logic          irq_clr;
    logic [31:0]   status_val;
    logic [31:0]   mmio_rdata;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign ram_hit    = (addr_i[31:AW+2] == '0);
    assign mmio_hit   = (addr_i[31:5] == MMIO_BASE[31:5]);
    assign offset     = addr_i[4:2];
    assign ram_idx    = addr_i[AW+1:2];
    assign ld         = ce_i & ~we_i;
    assign st         = ce_i & we_i;
    assign unused_bits = ^addr_i[1:0];

    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = st & ~ram_hit & mmio_hit & (offset == OFF_TXDATA);
    assign pop        = tx_valid_o & tx_ready_i;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign do_push    = push & (~fifo_full | pop);

    assign irq_set    = (cyc_cnt[31:0] == timecmp) && (timecmp != '0);
    assign irq_clr    = st & ~ram_hit & mmio_hit & (offset == OFF_STATUS) & data_i[0];

    assign status_val = {24'd0, sat_count(fifo_cnt), overflow, fifo_empty, fifo_full, irq};

    assign irq_o      = irq;
    assign bus_err_o  = bus_err;
    assign tx_valid_o = ~fifo_empty;
    assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    // Load data is combinational; forced to zero while reset is held.
    assign data_o     = rst ? rdata : 32'd0;

    // MMIO register read mux.
    always_comb begin
        mmio_rdata = 32'd0;
        case (offset)
            OFF_CYCLE_LO: mmio_rdata = cyc_cnt[31:0];
            OFF_CYCLE_HI: mmio_rdata = hi_shadow;
            OFF_TIMECMP:  mmio_rdata = timecmp;
            OFF_STATUS:   mmio_rdata = status_val;
            default:      mmio_rdata = 32'd0;
        endcase
    end

    // Load data select: RAM, MMIO, or zero for stores/idle/unmapped.
    always_comb begin
        rdata = 32'd0;
        if (ld) begin
            if (ram_hit)       rdata = mem[ram_idx];
            else if (mmio_hit) rdata = mmio_rdata;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (st && ram_hit) mem[ram_idx] <= data_i;
    end

    // FIFO storage; only the pointers and count carry reset.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= data_i[7:0];
    end

    // Free-running cycle counter and the high-word snapshot taken on CYCLE_LO loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt   <= 64'd0;
            hi_shadow <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (ld && !ram_hit && mmio_hit && offset == OFF_CYCLE_LO)
                hi_shadow <= cyc_cnt[63:32];
        end
    end

    // Compare timer: TIMECMP register and the irq flag (set beats W1C clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timecmp <= 32'd0;
            irq     <= 1'b0;
        end else begin
            if (st && !ram_hit && mmio_hit && offset == OFF_TIMECMP)
                timecmp <= data_i;
            if (irq_set)      irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (st && !ram_hit && mmio_hit && offset == OFF_STATUS && data_i[3])
                overflow <= 1'b0;
        end
    end

    // Sticky bus error on any access that misses both RAM and the MMIO window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             bus_err <= 1'b0;
        else if (ce_i && !ram_hit && !mmio_hit) bus_err <= 1'b1;
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM path, cycle snapshot, timer, TX FIFO,
// bus error and asynchronous reset.
module tb_data_mem_mmio;

    localparam logic [31:0] B = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        irq_o;
    logic        bus_err_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [63:0] tb_cyc;
    logic [63:0] tb_off = 64'd0;
    logic [31:0] now;

    data_mem_mmio #(
        .RAM_WORDS (1024),
        .FIFO_DEPTH(8),
        .MMIO_BASE (B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce_i      (ce_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .irq_o     (irq_o),
        .bus_err_o (bus_err_o),
        .tx_data_o (tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i)
    );

    always #5 clk = ~clk;

    // Reference cycle count: increments every edge out of reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= 64'd0;
        else      tb_cyc <= tb_cyc + 64'd1;
    end

    function automatic logic [63:0] cyc_model();
        return tb_cyc + tb_off;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All drivers change just after a falling edge; checks land 2 ns later.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a;
        #2;
        check_eq(tag, data_o, exp);
        @(negedge clk);
        ce_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; tx_ready_i = 1'b0;
        idle(2);

        // Reset state, with a STATUS load pending to show data_o is held at zero.
        ce_i = 1'b1; addr_i = B + 32'h0C;
        #2;
        check_eq("rst_data_o", data_o, 0);
        check_eq("rst_tx_valid", tx_valid_o, 0);
        check_eq("rst_tx_data", tx_data_o, 0);
        check_eq("rst_irq", irq_o, 0);
        check_eq("rst_bus_err", bus_err_o, 0);
        @(negedge clk);
        ce_i = 1'b0; rst = 1'b1;

        do_load("status_after_rst", B + 32'h0C, 32'h04);
        do_load("cycle_lo_count", B, cyc_model() & 64'hFFFF_FFFF);

        // RAM path.
        do_store(32'h10, 32'hDEADBEEF);
        do_load("ram_rd", 32'h10, 32'hDEADBEEF);
        do_load("ram_rd_low_bits", 32'h13, 32'hDEADBEEF);
        do_store(32'hFFC, 32'h1234_5678);
        do_load("ram_last_word", 32'hFFC, 32'h1234_5678);
        ce_i = 1'b0; addr_i = 32'h10;
        #2;
        check_eq("ce_low_data_o", data_o, 0);
        idle(1);

        // Store data_o is zero; read-only MMIO store is ignored without bus error.
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; data_i = 32'h5555_AAAA;
        #2;
        check_eq("store_data_o", data_o, 0);
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0;
        do_store(B, 32'h1111_2222);
        check_eq("ro_store_no_err", bus_err_o, 0);

        // Cycle counter wrap: snapshot must capture the pre-wrap high word.
        force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFF;
        tb_off = 64'h0000_0000_FFFF_FFFF - tb_cyc;
        #1;
        release dut.cyc_cnt;
        do_load("cycle_lo_allones", B, 32'hFFFF_FFFF);
        do_load("cycle_hi_prewrap", B + 32'h04, 32'h0);
        do_load("cycle_lo_postwrap", B, cyc_model() & 64'hFFFF_FFFF);
        do_load("cycle_hi_postwrap", B + 32'h04, 32'h1);
        check_eq("irq_idle_cmp0", irq_o, 0);

        // Timer fires exactly at the edge where the low counter equals TIMECMP.
        now = 32'(cyc_model());
        do_store(B + 32'h08, now + 32'd5);
        for (int i = 1; i <= 5; i++) begin
            check_eq("irq_before_match", irq_o, 0);
            idle(1);
        end
        check_eq("irq_at_match", irq_o, 1);
        do_load("timecmp_rd", B + 32'h08, now + 32'd5);
        do_load("status_irq", B + 32'h0C, 32'h05);
        do_store(B + 32'h0C, 32'h1);
        check_eq("irq_w1c", irq_o, 0);

        // Set and W1C clear land on the same edge: set wins.
        now = 32'(cyc_model());
        do_store(B + 32'h08, now + 32'd3);
        idle(2);
        do_store(B + 32'h0C, 32'h1);
        check_eq("irq_set_wins", irq_o, 1);
        do_store(B + 32'h0C, 32'h1);
        check_eq("irq_clear_again", irq_o, 0);

        // FIFO fill with sink stalled, then overflow.
        for (int i = 0; i < 8; i++) do_store(B + 32'h10, 32'h41 + i);
        do_load("status_full", B + 32'h0C, 32'h82);
        check_eq("head_full", tx_data_o, 8'h41);
        do_store(B + 32'h10, 32'h49);
        do_load("status_overflow", B + 32'h0C, 32'h8A);
        do_load("txdata_rd_zero", B + 32'h10, 32'h0);
        do_load("undef_rd_zero", B + 32'h1C, 32'h0);
        do_store(B + 32'h0C, 32'h8);
        do_load("status_ovf_clr", B + 32'h0C, 32'h82);

        // Drain in order.
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            check_eq("drain_valid", tx_valid_o, 1);
            check_eq("drain_byte", tx_data_o, 8'h41 + i);
            @(negedge clk);
        end
        #2;
        check_eq("drained_valid", tx_valid_o, 0);
        check_eq("drained_data", tx_data_o, 0);
        @(negedge clk);
        do_load("status_empty", B + 32'h0C, 32'h04);

        // Full FIFO with push and pop on the same edge.
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) do_store(B + 32'h10, 32'h50 + i);
        tx_ready_i = 1'b1;
        do_store(B + 32'h10, 32'h58);
        tx_ready_i = 1'b0;
        do_load("status_pushpop_full", B + 32'h0C, 32'h82);
        check_eq("head_after_pushpop", tx_data_o, 8'h51);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            check_eq("drain2_byte", tx_data_o, 8'h51 + i);
            @(negedge clk);
        end
        #2;
        check_eq("drain2_valid", tx_valid_o, 0);
        @(negedge clk);
        tx_ready_i = 1'b0;

        // Unmapped access: zero data, sticky bus error.
        check_eq("bus_err_before", bus_err_o, 0);
        do_load("unmapped_rd", 32'h2000_0000, 32'h0);
        check_eq("bus_err_set", bus_err_o, 1);
        idle(1);
        check_eq("bus_err_sticky", bus_err_o, 1);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) do_store(B + 32'h10, 32'h61 + i);
        tx_ready_i = 1'b1;
        idle(1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_valid", tx_valid_o, 0);
        check_eq("async_rst_data", tx_data_o, 0);
        check_eq("async_rst_bus_err", bus_err_o, 0);
        @(negedge clk);
        tx_ready_i = 1'b0;
        tb_off = 64'd0;
        rst = 1'b1;
        do_load("status_after_async_rst", B + 32'h0C, 32'h04);
        do_load("cycle_hi_after_rst", B + 32'h04, 32'h0);
        do_load("ram_survives_rst", 32'h10, 32'h5555_AAAA);

        // First byte past RAM is unmapped.
        do_load("ram_end_unmapped", 32'h1000, 32'h0);
        check_eq("ram_end_bus_err", bus_err_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
